// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and helpers for the direct-mapped write-through data cache.
//   state_e      - controller states (IDLE / FILL / WRITE)
//   req_t        - request captured when a miss or store leaves IDLE
//   byte_select  - extract one byte lane, zero-extended to a word
//   lane_enable  - byte-enable mask for a word or byte access
//   byte_merge   - merge new lanes into an existing word under a byte-enable mask
package dcache_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned LANES  = WORD_W / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_e;

    typedef struct packed {
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
        logic              byte_op;
    } req_t;

    // Little-endian lane pick: byte n lives in word[8n+7:8n].
    function automatic logic [WORD_W-1:0] byte_select(input logic [WORD_W-1:0] word,
                                                      input logic [1:0]        off);
        logic [7:0] b;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return WORD_W'(b);
    endfunction

    function automatic logic [LANES-1:0] lane_enable(input logic       byte_op,
                                                     input logic [1:0] off);
        logic [LANES-1:0] be;
        if (byte_op) begin
            be = LANES'(1) << off;
        end else begin
            be = '1;
        end
        return be;
    endfunction

    function automatic logic [WORD_W-1:0] byte_merge(input logic [WORD_W-1:0] old_word,
                                                     input logic [WORD_W-1:0] new_word,
                                                     input logic [LANES-1:0]  be);
        logic [WORD_W-1:0] res;
        for (int i = 0; i < int'(LANES); i++) begin
            res[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// dcache_array: valid/tag/data storage for a direct-mapped cache of one-word lines.
//   i_clk, i_rst          - clock, synchronous active-high reset (clears valid bits only)
//   i_rd_idx              - asynchronous read index
//   o_rd_valid/tag/data   - contents of the addressed line
//   i_wr_en, i_wr_idx     - synchronous write strobe and index
//   i_wr_tag              - tag stored with the line (line is marked valid)
//   i_wr_be, i_wr_data    - byte-enable and data for the line word
module dcache_array
    import dcache_pkg::*;
#(
    parameter int unsigned SETS  = 16,
    parameter int unsigned IDX_W = $clog2(SETS),
    parameter int unsigned TAG_W = 26
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic              o_rd_valid,
    output logic [TAG_W-1:0]  o_rd_tag,
    output logic [WORD_W-1:0] o_rd_data,
    input  logic              i_wr_en,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [TAG_W-1:0]  i_wr_tag,
    input  logic [LANES-1:0]  i_wr_be,
    input  logic [WORD_W-1:0] i_wr_data
);

    logic [SETS-1:0]   r_valid;
    logic [TAG_W-1:0]  r_tag  [SETS];
    logic [WORD_W-1:0] r_data [SETS];

    // Valid bits: the only state that reset touches.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    // Tag/data: a write coinciding with reset is dropped so no half-filled line survives.
    always_ff @(posedge i_clk) begin
        if (!i_rst && i_wr_en) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= byte_merge(r_data[i_wr_idx], i_wr_data, i_wr_be);
        end
    end

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[i_rd_idx];

endmodule

// File: rtl/dcache_direct.sv
// dcache_direct: direct-mapped, write-through, no-write-allocate data cache.
//   clk, rst                  - clock, synchronous active-high reset
//   addr_i, wdata_i           - M-stage byte address and store data (byte stores use [7:0])
//   re_i, we_i, byte_op_i     - load / store request, byte access qualifier
//   rdata_o                   - load result (combinational, zero-extended for bytes)
//   stall_o                   - freeze the pipeline while a fill or write-through is outstanding
//   mem_req_o, mem_we_o       - memory request valid, write (1) / word read (0)
//   mem_addr_o, mem_wdata_o   - memory address and write data
//   mem_byte_o                - byte-write qualifier
//   mem_ack_i, mem_rdata_i    - memory completion and read word
module dcache_direct
    import dcache_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SETS       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic                  we_i,
    input  logic                  byte_op_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  stall_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic                  mem_byte_o,
    input  logic                  mem_ack_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = DATA_WIDTH - IDX_W - 2;

    state_e                r_state;
    state_e                w_next;
    req_t                  r_req;
    logic [DATA_WIDTH-1:0] r_mem_addr;

    logic [IDX_W-1:0]      w_idx;
    logic [TAG_W-1:0]      w_tag;
    logic [1:0]            w_off;
    logic [IDX_W-1:0]      w_req_idx;
    logic [TAG_W-1:0]      w_req_tag;

    logic                  w_rd_valid;
    logic [TAG_W-1:0]      w_rd_tag;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_hit;

    logic                  w_latch;
    logic                  w_wr_en;
    logic [IDX_W-1:0]      w_wr_idx;
    logic [TAG_W-1:0]      w_wr_tag;
    logic [LANES-1:0]      w_wr_be;
    logic [DATA_WIDTH-1:0] w_wr_data;

    // Address split of the live request and of the latched one.
    assign w_off     = addr_i[1:0];
    assign w_idx     = addr_i[IDX_W+1:2];
    assign w_tag     = addr_i[DATA_WIDTH-1:IDX_W+2];
    assign w_req_idx = r_req.addr[IDX_W+1:2];
    assign w_req_tag = r_req.addr[DATA_WIDTH-1:IDX_W+2];

    dcache_array #(
        .SETS  (SETS),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_rd_idx   (w_idx),
        .o_rd_valid (w_rd_valid),
        .o_rd_tag   (w_rd_tag),
        .o_rd_data  (w_rd_data),
        .i_wr_en    (w_wr_en),
        .i_wr_idx   (w_wr_idx),
        .i_wr_tag   (w_wr_tag),
        .i_wr_be    (w_wr_be),
        .i_wr_data  (w_wr_data)
    );

    assign w_hit = w_rd_valid && (w_rd_tag == w_tag);

    // State and captured request; reset abandons any outstanding transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_req      <= '0;
            r_mem_addr <= '0;
        end else begin
            r_state <= w_next;
            if (w_latch) begin
                r_req.addr    <= addr_i;
                r_req.wdata   <= wdata_i;
                r_req.byte_op <= byte_op_i;
                // Byte writes keep the byte address; everything else goes out word-aligned.
                r_mem_addr    <= (we_i && byte_op_i) ? addr_i : {addr_i[DATA_WIDTH-1:2], 2'b00};
            end
        end
    end

    // Next state, stall, load data and array write controls.
    always_comb begin
        w_next    = r_state;
        stall_o   = 1'b0;
        rdata_o   = '0;
        w_latch   = 1'b0;
        w_wr_en   = 1'b0;
        w_wr_idx  = w_idx;
        w_wr_tag  = w_tag;
        w_wr_be   = '0;
        w_wr_data = wdata_i;

        unique case (r_state)
            IDLE: begin
                if (we_i) begin
                    // Store wins over a simultaneous load; a hit updates the line now.
                    stall_o = 1'b1;
                    w_latch = 1'b1;
                    w_next  = WRITE;
                    if (w_hit) begin
                        w_wr_en   = 1'b1;
                        w_wr_be   = lane_enable(byte_op_i, w_off);
                        w_wr_data = byte_op_i ? {LANES{wdata_i[7:0]}} : wdata_i;
                    end
                end else if (re_i) begin
                    if (w_hit) begin
                        rdata_o = byte_op_i ? byte_select(w_rd_data, w_off) : w_rd_data;
                    end else begin
                        stall_o = 1'b1;
                        w_latch = 1'b1;
                        w_next  = FILL;
                    end
                end
            end
            FILL: begin
                stall_o = 1'b1;
                if (mem_ack_i) begin
                    // Forward the fill word in the ack cycle so the held load retires.
                    stall_o   = 1'b0;
                    rdata_o   = r_req.byte_op ? byte_select(mem_rdata_i, r_req.addr[1:0])
                                              : mem_rdata_i;
                    w_wr_en   = 1'b1;
                    w_wr_idx  = w_req_idx;
                    w_wr_tag  = w_req_tag;
                    w_wr_be   = '1;
                    w_wr_data = mem_rdata_i;
                    w_next    = IDLE;
                end
            end
            WRITE: begin
                stall_o = !mem_ack_i;
                if (mem_ack_i) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign mem_req_o   = (r_state != IDLE);
    assign mem_we_o    = (r_state == WRITE);
    assign mem_byte_o  = (r_state == WRITE) && r_req.byte_op;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_req.wdata;

endmodule

// File: tb/tb_dcache_direct.sv
// tb_dcache_direct: randomized scoreboard bench for dcache_direct.
// Reference model: write-through keeps every valid line equal to memory, so the
// bench only tracks which tag each index holds plus a word-addressed memory image.
module tb_dcache_direct;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        re_i = 1'b0;
    logic        we_i = 1'b0;
    logic        byte_op_i = 1'b0;
    logic [31:0] rdata_o;
    logic        stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_byte_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    dcache_direct #(.DATA_WIDTH(32), .SETS(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .re_i        (re_i),
        .we_i        (we_i),
        .byte_op_i   (byte_op_i),
        .rdata_o     (rdata_o),
        .stall_o     (stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_byte_o  (mem_byte_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_load;
        logic [31:0] rdata;
        int          stall;
        int          req;
    } exp_t;

    typedef struct {
        bit          we;
        bit          byte_op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
    } mreq_t;

    exp_t        exp_q[$];
    mreq_t       mq[$];
    int          errors = 0;
    int          checks = 0;

    bit          line_v   [16];
    int unsigned line_tag [16];
    logic [31:0] mem_model [int unsigned];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_rd(input int unsigned wa);
        if (mem_model.exists(wa)) return mem_model[wa];
        return (wa * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Memory responder: checks each request against the expected one, acks after its waits.
    initial begin : responder
        mreq_t cur;
        bit    active = 1'b0;
        int    left = 0;
        cur = '{0, 0, '0, '0, '0, 0};
        forever begin
            @(negedge clk);
            if (rst || !mem_req_o) begin
                active    = 1'b0;
                mem_ack_i = 1'b0;
            end else begin
                if (!active) begin
                    active = 1'b1;
                    if (mq.size() == 0) begin
                        chk("unexpected_mem_req", 32'(mem_addr_o), 32'hFFFF_FFFF);
                        cur = '{0, 0, '0, '0, '0, 0};
                    end else begin
                        cur = mq.pop_front();
                        chk("mem_we", 32'(mem_we_o), 32'(cur.we));
                        chk("mem_addr", mem_addr_o, cur.addr);
                        if (cur.we) begin
                            chk("mem_byte", 32'(mem_byte_o), 32'(cur.byte_op));
                            if (cur.byte_op) chk("mem_wdata_b", 32'(mem_wdata_o[7:0]), 32'(cur.wdata[7:0]));
                            else             chk("mem_wdata", mem_wdata_o, cur.wdata);
                        end
                    end
                    left = cur.waits;
                end
                if (left == 0) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = cur.rdata;
                end else begin
                    mem_ack_i   = 1'b0;
                    mem_rdata_i = $urandom;
                    left--;
                end
            end
        end
    end

    // Monitor: counts stall/request cycles per instruction and checks at retirement.
    initial begin : monitor
        int   stall_cnt = 0;
        int   req_cnt = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                stall_cnt = 0;
                req_cnt   = 0;
            end else if (re_i || we_i) begin
                if (mem_req_o) req_cnt++;
                if (stall_o) begin
                    stall_cnt++;
                end else begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_retire", addr_i, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.is_load) chk("load_rdata", rdata_o, e.rdata);
                        chk("stall_cycles", 32'(stall_cnt), 32'(e.stall));
                        chk("req_cycles", 32'(req_cnt), 32'(e.req));
                    end
                    stall_cnt = 0;
                    req_cnt   = 0;
                end
            end else begin
                chk("idle_rdata", rdata_o, 32'h0);
                chk("idle_stall", 32'(stall_o), 32'h0);
                chk("idle_req", 32'(mem_req_o), 32'h0);
            end
        end
    end

    // Issue one instruction, hold it while stalled, leave it after the retiring edge.
    task automatic issue(input bit re, input bit we, input bit bo, input logic [31:0] a,
                         input logic [31:0] wd, input int waits);
        int unsigned idx = (a >> 2) % 16;
        int unsigned tg  = a >> 6;
        int unsigned wa  = a >> 2;
        int unsigned off = a % 4;
        logic [31:0] w;
        exp_t        e;
        mreq_t       m;
        bit          done = 1'b0;
        w = mem_rd(wa);
        if (we) begin
            if (bo) w[off*8 +: 8] = wd[7:0];
            else    w = wd;
            mem_model[wa] = w;
            m = '{1, bo, bo ? a : (a & 32'hFFFF_FFFC), wd, '0, waits};
            mq.push_back(m);
            e = '{0, '0, 1 + waits, 1 + waits};
            exp_q.push_back(e);
        end else if (re) begin
            e.is_load = 1'b1;
            e.rdata   = bo ? ((w >> (8 * off)) & 32'hFF) : w;
            if (line_v[idx] && line_tag[idx] == tg) begin
                e.stall = 0;
                e.req   = 0;
            end else begin
                m = '{0, 0, a & 32'hFFFF_FFFC, '0, w, waits};
                mq.push_back(m);
                e.stall = 1 + waits;
                e.req   = 1 + waits;
                line_v[idx]   = 1'b1;
                line_tag[idx] = tg;
            end
            exp_q.push_back(e);
        end
        re_i = re; we_i = we; byte_op_i = bo; addr_i = a; wdata_i = wd;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            #2;
            if (!stall_o) done = 1'b1;
        end
        if (!done) chk("retire_timeout", 32'(stall_o), 32'h0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        re_i = 1'b0; we_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) line_v[i] = 1'b0;
        exp_q.delete();
        mq.delete();
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        clear_model();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #2;
        chk("reset_req", 32'(mem_req_o), 32'h0);
        chk("reset_we", 32'(mem_we_o), 32'h0);
        chk("reset_stall", 32'(stall_o), 32'h0);
        chk("reset_rdata", rdata_o, 32'h0);
        @(posedge clk);
        #1;

        // Directed scenarios.
        mem_model[32'h40 >> 2] = 32'hDEAD_BEEF;
        issue(1, 0, 0, 32'h40, '0, 2);            // cold miss, 3 stall cycles
        issue(1, 0, 0, 32'h40, '0, 0);            // hit
        issue(1, 0, 1, 32'h43, '0, 0);            // lbu -> DE
        issue(1, 0, 1, 32'h40, '0, 0);            // lbu -> EF
        issue(0, 1, 1, 32'h41, 32'h0000_0055, 1); // sb hit
        issue(1, 0, 0, 32'h40, '0, 0);            // DEAD55EF
        idle_cycle();
        issue(0, 1, 0, 32'h80, 32'h1234_5678, 0); // sw miss, no allocate
        issue(1, 0, 0, 32'h80, '0, 1);            // still misses, evicts 0x40
        issue(1, 0, 0, 32'h40, '0, 0);            // conflict miss

        // Reset while a fill is waiting for its ack.
        mq.push_back('{0, 0, 32'h0000_00C0, '0, 32'hAAAA_AAAA, 20});
        re_i = 1'b1; we_i = 1'b0; byte_op_i = 1'b0; addr_i = 32'hC0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1; re_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_model();
        @(negedge clk);
        #2;
        chk("rst_fill_req", 32'(mem_req_o), 32'h0);
        chk("rst_fill_stall", 32'(stall_o), 32'h0);
        @(posedge clk);
        #1;
        issue(1, 0, 0, 32'h40, '0, 1);            // cache was cleared: miss

        // Randomized traffic over a small address pool to mix hits and conflicts.
        for (int n = 0; n < 400; n++) begin
            int unsigned kind = $urandom_range(0, 9);
            bit          bo   = 1'($urandom_range(0, 1));
            int unsigned tg   = $urandom_range(1, 3);
            int unsigned idx  = $urandom_range(0, 15);
            int unsigned off  = bo ? $urandom_range(0, 3) : 0;
            logic [31:0] a    = 32'((tg << 6) | (idx << 2) | off);
            logic [31:0] wd   = $urandom;
            int          wt   = $urandom_range(0, 3);
            if (kind <= 4)      issue(1, 0, bo, a, wd, wt);
            else if (kind <= 7) issue(0, 1, bo, a, wd, wt);
            else if (kind == 8) issue(1, 1, bo, a, wd, wt);
            else                idle_cycle();
        end

        idle_cycle();
        repeat (2) @(posedge clk);
        #1;
        chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
        chk("mem_q_drained", 32'(mq.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dcache_direct.md
Name: dcache_direct

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the memory-stage signals (ALUResultM, WriteDataM, MemWriteM, ByteOpM) and a handshaked main data memory.
- Returns hit data combinationally in the same cycle.
- Raises stall_o to freeze the pipeline while a miss fill or a write-through is outstanding.

Parameters:
- DATA_WIDTH, 32, data and address width.
- SETS, 16, number of one-word lines. Must be a power of 2, at least 2.
- IDX_W, $clog2(SETS), index width (derived localparam).

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, synchronous active-high reset.
- addr_i, input, DATA_WIDTH, byte address from the M stage.
- wdata_i, input, DATA_WIDTH, store data; byte stores use bits [7:0].
- re_i, input, 1, load request.
- we_i, input, 1, store request.
- byte_op_i, input, 1, 1 = byte access (lbu/sb), 0 = word access.
- rdata_o, output, DATA_WIDTH, load result; byte loads are zero-extended.
- stall_o, output, 1, hold all pipeline registers this cycle.
- mem_req_o, output, 1, memory request valid.
- mem_we_o, output, 1, 1 = write, 0 = word read.
- mem_addr_o, output, DATA_WIDTH, word-aligned for reads, byte address for byte writes.
- mem_wdata_o, output, DATA_WIDTH, write data.
- mem_byte_o, output, 1, byte-write qualifier.
- mem_ack_i, input, 1, memory completes the request this cycle; read data valid.
- mem_rdata_i, input, DATA_WIDTH, read word.

Behaviour:
- Address split: offset = addr_i[1:0]; index = addr_i[IDX_W+1:2]; tag = addr_i[DATA_WIDTH-1:IDX_W+2]. Little-endian byte select: byte n = word[8n+7:8n].
- Storage per line: valid bit, tag, 32-bit word. Hit = valid[index] && tag match.
- Reset: all valid bits cleared, state IDLE. mem_req_o=0, mem_we_o=0, stall_o=0, rdata_o=0 while re_i=0.
- Reset mid-transaction: state returns to IDLE at that edge, and mem_req_o is low the next cycle. The memory must drop the request; no line is written.
- States: IDLE, FILL, WRITE.
- IDLE with re_i and hit:
  - rdata_o is valid combinationally; stall_o=0; no memory traffic.
- IDLE with re_i and miss:
  - stall_o=1 combinationally.
  - Next state FILL; mem_addr_o = {addr_i[31:2],2'b00} is registered.
- FILL:
  - mem_req_o=1, mem_we_o=0; address and controls held stable until mem_ack_i.
  - On the ack cycle: rdata_o is taken from mem_rdata_i (with byte select), stall_o=0, and line valid/tag/data are written at that edge.
  - Next state IDLE.
- IDLE with we_i:
  - stall_o=1; next state WRITE.
  - The request (addr_i, wdata_i, byte_op_i) is latched.
  - On a hit, the line is updated at this edge: the whole word, or only the addressed byte lane when byte_op_i=1.
  - On a miss, the cache is not modified.
- WRITE:
  - mem_req_o=1, mem_we_o=1; stall_o = !mem_ack_i. The pipeline advances on the ack edge.
  - Next state IDLE.
- Completing in the ack cycle prevents the same held instruction from re-issuing.
- re_i and we_i both high: treated as a store; the load is ignored.
- re_i=0 and we_i=0: rdata_o=0, no state change.
- Back-to-back requests: a new request is accepted in the first IDLE cycle after an ack. There are no bubbles beyond the handshake.
- Latency:
  - Hit: 0 cycles.
  - Miss or store: 1 + N cycles of stall, where N is the number of cycles from mem_req_o rising until mem_ack_i (N ≥ 0 extra waits; ack may arrive the first FILL/WRITE cycle).
- mem_ack_i in IDLE is ignored.

Decomposition:
- Package dcache_pkg: state enum typedef (IDLE/FILL/WRITE); byte-select function (word, offset) -> zero-extended byte; byte-lane merge function.
- Sub-module: dcache_array (valid/tag/data storage).
  - Synchronous write, asynchronous read, reset clears valid.
  - Byte-enable write port.
- The FSM stays in dcache_direct.

Test Plan:
- Cold read: reset, then re_i at 0x0000_0040; memory acks after 2 waits with 0xDEADBEEF -> stall_o high for 3 cycles, rdata_o=0xDEADBEEF on the ack cycle. Re-read the next cycle -> hit, stall_o=0, mem_req_o=0.
- Byte load: line 0x40 holds 0xDEADBEEF; lbu 0x43 -> rdata_o=0x000000DE. lbu 0x40 -> 0x000000EF.
- Store hit: sb 0x41 data 0x55 -> mem write with byte 0x41, mem_byte_o=1. Then lw 0x40 hits -> 0xDEAD55EF.
- Store miss: sw 0x80 = 0x12345678 -> mem write issued. Then lw 0x80 misses (no allocate), mem_req_o=1 with mem_we_o=0.
- Conflict eviction, SETS=16: load 0x40, then 0x80 (same index 0) -> both miss. Re-load 0x40 -> miss again.
- Reset during FILL: rst while waiting for ack -> next cycle mem_req_o=0, stall_o=0. Re-read 0x40 -> misses.
